// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
package dmem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [3:0] WEN_READ = 4'b0000;
    localparam int         STAT_W   = 16;
    localparam int         CNT_W    = 4;

    // Misaligned, or outside the 2^addr_w-word window.
    function automatic logic addr_bad(input logic [31:0] addr, input int addr_w);
        logic [31:0] hi;
        hi = addr >> (addr_w + 2);
        return (addr[1:0] != 2'b00) || (hi != 32'd0);
    endfunction

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (v == {STAT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// 2^ADDR_W x 32 storage: one byte-masked write/read port returning the
// post-write word, plus a registered read-before-write debug port.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              en,
    input  logic [3:0]        wen,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [31:0]       dbg_data
);

    logic [31:0] mem [2**ADDR_W];
    logic [31:0] merged;
    logic [31:0] rdata_q;
    logic [31:0] dbg_data_q;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign merged[gi*8 +: 8] = wen[gi] ? wdata[gi*8 +: 8] : mem[addr][gi*8 +: 8];
        end
    endgenerate

    // Storage carries no reset; a read (wen==0) rewrites the same word.
    always_ff @(posedge clk) begin
        if (en) begin
            mem[addr] <= merged;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rdata_q    <= 32'h0;
            dbg_data_q <= 32'h0;
        end else begin
            if (en) begin
                rdata_q <= merged;
            end
            dbg_data_q <= mem[dbg_addr];
        end
    end

    assign rdata    = rdata_q;
    assign dbg_data = dbg_data_q;

endmodule

// File: rtl/dmem_responder.sv
// Variable-latency data-memory responder for the CPU MEM stage.
// Optional statistics counters are built when DMEM_STATS_EN is defined.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        req_wen,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    input  logic [31:0]       dbg_addr,
    output logic [31:0]       dbg_data,
    output logic [STAT_W-1:0] stat_rd,
    output logic [STAT_W-1:0] stat_wr,
    output logic [STAT_W-1:0] stat_err
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY > 1 ? LATENCY - 2 : 0);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       wen_q, wen_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic             err_q, err_d;

    logic [3:0]       cur_wen;
    logic [31:0]      cur_addr;
    logic [31:0]      cur_wdata;
    logic             cur_err;
    logic             enter_resp;
    logic             mem_en;
    logic [31:0]      mem_rdata;
    logic             unused_dbg_bits;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        wen_d      = wen_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    wen_d   = req_wen;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    if (LATENCY > 1) begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_LOAD;
                    end else begin
                        state_d = ST_RESP;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_RESP: begin
                resp_valid = 1'b1;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // With LATENCY==1 the edge entering RESP is the acceptance edge, so the
    // live request is used there instead of the not-yet-latched copy.
    assign cur_wen    = (state_q == ST_IDLE) ? req_wen   : wen_q;
    assign cur_addr   = (state_q == ST_IDLE) ? req_addr  : addr_q;
    assign cur_wdata  = (state_q == ST_IDLE) ? req_wdata : wdata_q;
    assign cur_err    = addr_bad(cur_addr, ADDR_W);
    assign enter_resp = (state_d == ST_RESP);
    assign mem_en     = enter_resp && !cur_err;
    assign err_d      = enter_resp ? cur_err : err_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            wen_q   <= WEN_READ;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wen_q   <= wen_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
        end
    end

    dmem_array #(.ADDR_W(ADDR_W)) u_array (
        .clk      (clk),
        .resetn   (resetn),
        .en       (mem_en),
        .wen      (cur_wen),
        .addr     (cur_addr[ADDR_W+1:2]),
        .wdata    (cur_wdata),
        .rdata    (mem_rdata),
        .dbg_addr (dbg_addr[ADDR_W+1:2]),
        .dbg_data (dbg_data)
    );

    assign unused_dbg_bits = ^{dbg_addr[31:ADDR_W+2], dbg_addr[1:0]};

    assign resp_rdata = err_q ? 32'h0 : mem_rdata;
    assign resp_err   = err_q && (state_q == ST_RESP);

`ifdef DMEM_STATS_EN
    logic [STAT_W-1:0] stat_rd_q, stat_rd_d;
    logic [STAT_W-1:0] stat_wr_q, stat_wr_d;
    logic [STAT_W-1:0] stat_err_q, stat_err_d;

    always_comb begin
        stat_rd_d  = stat_rd_q;
        stat_wr_d  = stat_wr_q;
        stat_err_d = stat_err_q;
        if (state_q == ST_RESP) begin
            if (err_q) begin
                stat_err_d = sat_inc(stat_err_q);
            end else if (wen_q == WEN_READ) begin
                stat_rd_d = sat_inc(stat_rd_q);
            end else begin
                stat_wr_d = sat_inc(stat_wr_q);
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stat_rd_q  <= '0;
            stat_wr_q  <= '0;
            stat_err_q <= '0;
        end else begin
            stat_rd_q  <= stat_rd_d;
            stat_wr_q  <= stat_wr_d;
            stat_err_q <= stat_err_d;
        end
    end

    assign stat_rd  = stat_rd_q;
    assign stat_wr  = stat_wr_q;
    assign stat_err = stat_err_q;
`else
    assign stat_rd  = '0;
    assign stat_wr  = '0;
    assign stat_err = '0;
`endif

endmodule
